// File: rtl/arp_pkg.sv
// Shared ARP definitions for the receive and transmit paths.
// Holds Ethernet/ARP header constants, frame geometry, the FSM state
// encoding and small byte-select helpers for big-endian fields.
package arp_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_HTYPE     = 16'h0001;
  localparam logic [15:0] ARP_PTYPE     = 16'h0800;
  localparam logic [7:0]  ARP_HLEN      = 8'h06;
  localparam logic [7:0]  ARP_PLEN      = 8'h04;
  localparam logic [15:0] OP_REQ        = 16'h0001;
  localparam logic [15:0] OP_REP        = 16'h0002;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hd5;
  localparam int          BODY_LEN      = 60;
  localparam int          FCS_LEN       = 4;
  localparam int          MAX_PREAMBLE  = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_BODY,
    ST_FCS,
    ST_CHECK,
    ST_DROP
  } arp_state_e;

  // idx 0 = most significant byte (first on the wire)
  function automatic logic [7:0] be_byte48(input logic [47:0] v, input logic [2:0] idx);
    return v[47 - 8*int'(idx) -: 8];
  endfunction

  function automatic logic [7:0] be_byte32(input logic [31:0] v, input logic [1:0] idx);
    return v[31 - 8*int'(idx) -: 8];
  endfunction

endpackage

// File: rtl/arp_rx.sv
// ARP frame receiver on the GMII byte path.
// Parses preamble/SFD, a 60-byte body and a 4-byte FCS, checks the Ethernet
// and ARP header fields and (optionally) the FCS against the shared CRC core,
// then reports the sender MAC/IP and opcode of good frames.
// Ports:
//   arp_tx_clk, rstn (sync, active-low)
//   rx_data/rx_valid         : incoming byte stream
//   crc_data                 : final-form CRC32 from the external core
//   crc_din/crc_en/crc_init  : drive the external CRC core
//   arp_rx_done/arp_rx_err   : one-cycle result pulses
//   arp_rx_op/src_mac/src_ip : fields of the last good frame
module arp_rx
  import arp_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] FPGA_IP   = 32'hc0_a8_00_03,
  parameter bit          CRC_CHECK = 1'b1
) (
  input  logic        arp_tx_clk,
  input  logic        rstn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [31:0] crc_data,
  output logic [7:0]  crc_din,
  output logic        crc_en,
  output logic        crc_init,
  output logic        arp_rx_done,
  output logic        arp_rx_err,
  output logic        arp_rx_op,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  arp_state_e  state;
  logic [6:0]  cnt;
  logic [2:0]  pre_cnt;
  logic [1:0]  chk_cnt;
  logic        err_flag;
  logic        post_sfd;   // drop happened after SFD -> report it
  logic        dst_bc;     // dst MAC bytes so far all 8'hff
  logic        dst_uc;     // dst MAC bytes so far match FPGA_MAC
  logic [31:0] fcs_rx;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;
  logic        op_sh;

  // Running destination-MAC match including the current byte
  logic bc_n, uc_n, crc_bad;
  assign bc_n    = ((cnt == 7'd0) || dst_bc) && (rx_data == 8'hff);
  assign uc_n    = ((cnt == 7'd0) || dst_uc) && (rx_data == be_byte48(FPGA_MAC, cnt[2:0]));
  assign crc_bad = CRC_CHECK && (fcs_rx != crc_data);

  assign crc_init = (state == ST_IDLE) || (state == ST_PREAMBLE);

  always_ff @(posedge arp_tx_clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      pre_cnt     <= '0;
      chk_cnt     <= '0;
      err_flag    <= 1'b0;
      post_sfd    <= 1'b0;
      dst_bc      <= 1'b0;
      dst_uc      <= 1'b0;
      fcs_rx      <= '0;
      mac_sh      <= '0;
      ip_sh       <= '0;
      op_sh       <= 1'b0;
      crc_din     <= '0;
      crc_en      <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_err  <= 1'b0;
      arp_rx_op   <= 1'b0;
      src_mac     <= '0;
      src_ip      <= '0;
    end else begin
      crc_din     <= rx_data;
      crc_en      <= (state == ST_BODY) && rx_valid;
      arp_rx_done <= 1'b0;
      arp_rx_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          err_flag <= 1'b0;
          post_sfd <= 1'b0;
          pre_cnt  <= 3'd1;
          if (rx_valid)
            state <= (rx_data == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
        end

        ST_PREAMBLE: begin
          if (!rx_valid)
            state <= ST_DROP;
          else if (rx_data == PREAMBLE_BYTE) begin
            if (pre_cnt == 3'(MAX_PREAMBLE)) state <= ST_DROP;
            else                            pre_cnt <= pre_cnt + 3'd1;
          end else if (rx_data == SFD_BYTE) begin
            state    <= ST_BODY;
            cnt      <= '0;
            err_flag <= 1'b0;
          end else
            state <= ST_DROP;
        end

        ST_BODY: begin
          if (!rx_valid) begin
            err_flag <= 1'b1;
            post_sfd <= 1'b1;
            state    <= ST_DROP;
          end else begin
            // Field checks flag errors but never stop parsing
            if (cnt <= 7'd5) begin
              dst_bc <= bc_n;
              dst_uc <= uc_n;
              if (cnt == 7'd5 && !bc_n && !uc_n) err_flag <= 1'b1;
            end else if (cnt == 7'd12) begin
              if (rx_data != ETH_TYPE_ARP[15:8]) err_flag <= 1'b1;
            end else if (cnt == 7'd13) begin
              if (rx_data != ETH_TYPE_ARP[7:0]) err_flag <= 1'b1;
            end else if (cnt == 7'd14) begin
              if (rx_data != ARP_HTYPE[15:8]) err_flag <= 1'b1;
            end else if (cnt == 7'd15) begin
              if (rx_data != ARP_HTYPE[7:0]) err_flag <= 1'b1;
            end else if (cnt == 7'd16) begin
              if (rx_data != ARP_PTYPE[15:8]) err_flag <= 1'b1;
            end else if (cnt == 7'd17) begin
              if (rx_data != ARP_PTYPE[7:0]) err_flag <= 1'b1;
            end else if (cnt == 7'd18) begin
              if (rx_data != ARP_HLEN) err_flag <= 1'b1;
            end else if (cnt == 7'd19) begin
              if (rx_data != ARP_PLEN) err_flag <= 1'b1;
            end else if (cnt == 7'd20) begin
              if (rx_data != OP_REQ[15:8]) err_flag <= 1'b1;
            end else if (cnt == 7'd21) begin
              if (rx_data == OP_REQ[7:0])      op_sh <= 1'b1;
              else if (rx_data == OP_REP[7:0]) op_sh <= 1'b0;
              else                             err_flag <= 1'b1;
            end else if (cnt >= 7'd22 && cnt <= 7'd27) begin
              mac_sh <= {mac_sh[39:0], rx_data};
            end else if (cnt >= 7'd28 && cnt <= 7'd31) begin
              ip_sh <= {ip_sh[23:0], rx_data};
            end else if (cnt >= 7'd38 && cnt <= 7'd41) begin
              if (rx_data != be_byte32(FPGA_IP, 2'(cnt - 7'd38))) err_flag <= 1'b1;
            end
            cnt <= cnt + 7'd1;
            if (cnt == 7'(BODY_LEN - 1)) state <= ST_FCS;
          end
        end

        ST_FCS: begin
          if (!rx_valid) begin
            err_flag <= 1'b1;
            post_sfd <= 1'b1;
            state    <= ST_DROP;
          end else begin
            // cnt 60..63 -> low two bits select the byte lane, first byte lowest
            fcs_rx[8*int'(cnt[1:0]) +: 8] <= rx_data;
            cnt <= cnt + 7'd1;
            if (cnt == 7'(BODY_LEN + FCS_LEN - 1)) begin
              chk_cnt <= '0;
              state   <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (rx_valid)
            err_flag <= 1'b1;  // oversize frame; resolve once the line idles
          else if (chk_cnt != 2'd2)
            chk_cnt <= chk_cnt + 2'd1;  // let the CRC core settle
          else begin
            if (err_flag || crc_bad)
              arp_rx_err <= 1'b1;
            else begin
              arp_rx_done <= 1'b1;
              arp_rx_op   <= op_sh;
              src_mac     <= mac_sh;
              src_ip      <= ip_sh;
            end
            state <= ST_IDLE;
          end
        end

        ST_DROP: begin
          if (!rx_valid) begin
            arp_rx_err <= post_sfd;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// Directed bench for arp_rx: two DUTs (FCS checked / ignored) fed the same
// byte stream, each with its own behavioural CRC32 core.
module tb_arp_rx;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;

  logic [31:0] crc_data0, crc_data1, crc_r0, crc_r1;
  logic [7:0]  crc_din0, crc_din1;
  logic        crc_en0, crc_en1, crc_init0, crc_init1;
  logic        done0, err0, op0, done1, err1, op1;
  logic [47:0] mac0, mac1;
  logic [31:0] ip0, ip1;

  always #5 clk = ~clk;

  arp_rx #(.CRC_CHECK(1'b1)) u_dut0 (
    .arp_tx_clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .crc_data(crc_data0), .crc_din(crc_din0), .crc_en(crc_en0), .crc_init(crc_init0),
    .arp_rx_done(done0), .arp_rx_err(err0), .arp_rx_op(op0), .src_mac(mac0), .src_ip(ip0));

  arp_rx #(.CRC_CHECK(1'b0)) u_dut1 (
    .arp_tx_clk(clk), .rstn(rstn), .rx_data(rx_data), .rx_valid(rx_valid),
    .crc_data(crc_data1), .crc_din(crc_din1), .crc_en(crc_en1), .crc_init(crc_init1),
    .arp_rx_done(done1), .arp_rx_err(err1), .arp_rx_op(op1), .src_mac(mac1), .src_ip(ip1));

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // External CRC cores
  always @(posedge clk) begin
    if (crc_init0) crc_r0 <= 32'hffffffff; else if (crc_en0) crc_r0 <= crc_byte(crc_r0, crc_din0);
    if (crc_init1) crc_r1 <= 32'hffffffff; else if (crc_en1) crc_r1 <= crc_byte(crc_r1, crc_din1);
  end
  assign crc_data0 = ~crc_r0;
  assign crc_data1 = ~crc_r1;

  int tests = 0, fails = 0;
  int cyc = 0, low_cyc = 0, done_cyc = 0;
  int done_n0 = 0, err_n0 = 0, done_n1 = 0, err_n1 = 0, both_n = 0;
  int rst_seen = 0, bad_init = 0;
  logic rst_q = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rstn;
  end

  always @(negedge clk) begin
    if (done0) begin done_n0++; done_cyc = cyc; end
    if (err0) err_n0++;
    if (done1) done_n1++;
    if (err1) err_n1++;
    if ((done0 && err0) || (done1 && err1)) both_n++;
    if (!rst_q) begin rst_seen++; if (crc_init0 !== 1'b1) bad_init++; end
  end

  logic [7:0] fr [64];

  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] op,
                       input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip);
    logic [31:0] c;
    for (int i = 0; i < 64; i++) fr[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fr[i]    = dst[47-8*i -: 8];
      fr[6+i]  = (i == 5) ? 8'h01 : ((i == 0) ? 8'h02 : 8'h00);
      fr[22+i] = smac[47-8*i -: 8];
    end
    fr[12] = etype[15:8]; fr[13] = etype[7:0];
    fr[14] = 8'h00; fr[15] = 8'h01; fr[16] = 8'h08; fr[17] = 8'h00;
    fr[18] = 8'h06; fr[19] = 8'h04; fr[20] = op[15:8]; fr[21] = op[7:0];
    for (int i = 0; i < 4; i++) begin
      fr[28+i] = sip[31-8*i -: 8];
      fr[38+i] = tip[31-8*i -: 8];
    end
    c = 32'hffffffff;
    for (int i = 0; i < 60; i++) c = crc_byte(c, fr[i]);
    c = ~c;
    for (int i = 0; i < 4; i++) fr[60+i] = c[8*i +: 8];
  endtask

  task automatic drive(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  // npre x 55, d5, fr[0..nbytes-1], extra trailing zero bytes; rstn low for bytes rs..re
  task automatic send(input int npre, input int nbytes, input int rs, input int re, input int extra);
    for (int p = 0; p < npre; p++) drive(8'h55);
    drive(8'hd5);
    for (int i = 0; i < nbytes; i++) begin
      drive(fr[i]);
      rstn = !(i >= rs && i <= re);
    end
    for (int e = 0; e < extra; e++) drive(8'h00);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rstn     = 1'b1;
    low_cyc  = cyc;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    done_n0 = 0; err_n0 = 0; done_n1 = 0; err_n1 = 0;
  endtask

  task automatic chk_cnt(input string name, input int dn, input int en, input int dx, input int ex);
    tests++;
    if (dn !== dx || en !== ex) begin
      fails++;
      $display("FAIL %s: done=%0d err=%0d, expected done=%0d err=%0d", name, dn, en, dx, ex);
    end
  endtask

  task automatic chk_out(input string name, input logic op, input logic [47:0] mac, input logic [31:0] ip,
                         input logic xop, input logic [47:0] xmac, input logic [31:0] xip);
    tests++;
    if (op !== xop || mac !== xmac || ip !== xip) begin
      fails++;
      $display("FAIL %s: op=%0b mac=%h ip=%h, expected op=%0b mac=%h ip=%h", name, op, mac, ip, xop, xmac, xip);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({done0, err0, crc_en0, crc_din0} !== 11'd0) begin
      fails++; $display("FAIL reset_pulses: got %h expected 0", {done0, err0, crc_en0, crc_din0});
    end
    tests++;
    if (crc_init0 !== 1'b1) begin fails++; $display("FAIL reset_crc_init: got %b expected 1", crc_init0); end
    chk_out("reset_outputs", op0, mac0, ip0, 1'b0, 48'h0, 32'h0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_request();
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h000a3501fec0, 32'hc0a80002, 32'hc0a80003);
    send(7, 64, -1, -1, 0);
    chk_cnt("request_pulses", done_n0, err_n0, 1, 0);
    chk_out("request_fields", op0, mac0, ip0, 1'b1, 48'h000a3501fec0, 32'hc0a80002);
    tests++;
    if (done_cyc - low_cyc !== 3) begin
      fails++; $display("FAIL request_latency: got %0d expected 3", done_cyc - low_cyc);
    end
    tests++;
    if (crc_init0 !== 1'b1) begin fails++; $display("FAIL idle_crc_init: got %b expected 1", crc_init0); end
  endtask

  task automatic test_reply();
    clr();
    build(48'h001122334455, 16'h0806, 16'h0002, 48'h02aabbccddee, 32'hc0a80010, 32'hc0a80003);
    send(7, 64, -1, -1, 0);
    chk_cnt("reply_pulses", done_n0, err_n0, 1, 0);
    chk_out("reply_fields", op0, mac0, ip0, 1'b0, 48'h02aabbccddee, 32'hc0a80010);
    clr();
    build(48'h001122334456, 16'h0806, 16'h0002, 48'h0c0d0e0f1011, 32'hc0a80020, 32'hc0a80003);
    send(7, 64, -1, -1, 0);
    chk_cnt("wrong_dst_pulses", done_n0, err_n0, 0, 1);
    chk_out("wrong_dst_hold", op0, mac0, ip0, 1'b0, 48'h02aabbccddee, 32'hc0a80010);
  endtask

  task automatic test_bad_fields();
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h000a3501fec0, 32'hc0a80002, 32'hc0a80004);
    send(7, 64, -1, -1, 0);
    chk_cnt("bad_tip", done_n0, err_n0, 0, 1);
    clr();
    build(48'hffffffffffff, 16'h0800, 16'h0001, 48'h000a3501fec0, 32'hc0a80002, 32'hc0a80003);
    send(7, 64, -1, -1, 0);
    chk_cnt("bad_ethertype", done_n0, err_n0, 0, 1);
  endtask

  task automatic test_fcs();
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80009, 32'hc0a80003);
    fr[61] = fr[61] ^ 8'h01;
    send(7, 64, -1, -1, 0);
    chk_cnt("fcs_bad_checked", done_n0, err_n0, 0, 1);
    chk_cnt("fcs_bad_ignored", done_n1, err_n1, 1, 0);
    chk_out("fcs_ignored_fields", op1, mac1, ip1, 1'b1, 48'h0a0b0c0d0e0f, 32'hc0a80009);
    chk_out("fcs_checked_hold", op0, mac0, ip0, 1'b0, 48'h02aabbccddee, 32'hc0a80010);
  endtask

  task automatic test_preamble();
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0002, 48'h111111111111, 32'hc0a80011, 32'hc0a80003);
    send(8, 64, -1, -1, 0);
    chk_cnt("preamble_8", done_n0, err_n0, 0, 0);
    clr();
    send(1, 64, -1, -1, 0);
    chk_cnt("preamble_1", done_n0, err_n0, 1, 0);
    chk_out("preamble_1_fields", op0, mac0, ip0, 1'b0, 48'h111111111111, 32'hc0a80011);
  endtask

  task automatic test_back_to_back();
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h222222222222, 32'hc0a80022, 32'hc0a80003);
    send(7, 64, -1, -1, 1);
    chk_cnt("too_long", done_n0, err_n0, 0, 1);
    clr();
    send(7, 32, -1, -1, 0);
    chk_cnt("truncated", done_n0, err_n0, 0, 1);
    clr();
    build(48'h001122334455, 16'h0806, 16'h0001, 48'h333333333333, 32'hc0a80033, 32'hc0a80003);
    send(7, 64, -1, -1, 0);
    chk_cnt("after_trunc", done_n0, err_n0, 1, 0);
    chk_out("after_trunc_fields", op0, mac0, ip0, 1'b1, 48'h333333333333, 32'hc0a80033);
  endtask

  task automatic test_reset_mid();
    clr();
    rst_seen = 0; bad_init = 0;
    build(48'hffffffffffff, 16'h0806, 16'h0001, 48'h000a3501fec0, 32'hc0a80002, 32'hc0a80003);
    send(7, 64, 20, 21, 0);
    chk_cnt("reset_mid_pulses", done_n0, err_n0, 0, 0);
    chk_out("reset_mid_cleared", op0, mac0, ip0, 1'b0, 48'h0, 32'h0);
    tests++;
    if (rst_seen == 0 || bad_init != 0) begin
      fails++; $display("FAIL reset_mid_crc_init: rst_cycles=%0d bad=%0d expected >0 and 0", rst_seen, bad_init);
    end
    clr();
    build(48'hffffffffffff, 16'h0806, 16'h0002, 48'h444444444444, 32'hc0a80044, 32'hc0a80003);
    send(7, 64, -1, -1, 0);
    chk_cnt("reset_mid_next", done_n0, err_n0, 1, 0);
    chk_out("reset_mid_next_fields", op0, mac0, ip0, 1'b0, 48'h444444444444, 32'hc0a80044);
  endtask

  initial begin
    test_reset();
    test_request();
    test_reply();
    test_bad_fields();
    test_fcs();
    test_preamble();
    test_back_to_back();
    test_reset_mid();
    tests++;
    if (both_n != 0) begin fails++; $display("FAIL done_err_overlap: got %0d expected 0", both_n); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/arp_rx.md
Name: arp_rx

Overview:
ARP frame receiver, the receive-side counterpart of the ARP transmitter on the RGMII/GMII byte path. It parses an incoming Ethernet byte stream (preamble, SFD, 60-byte frame body, 4-byte FCS) and validates the Ethernet and ARP header fields and the FCS. On a good frame it reports the ARP opcode plus the sender MAC and IP. The ARP top uses these results to trigger arp_tx (request in, reply out) and to learn the peer's MAC address.

Parameters:
FPGA_MAC, 48'h00_11_22_33_44_55, local MAC; accepted as destination MAC alongside broadcast.
FPGA_IP, 32'hc0_a8_00_03, local IP; the ARP target IP must equal this.
CRC_CHECK, 1, 1 = FCS mismatch rejects the frame; 0 = FCS bytes consumed but ignored.

Ports:
arp_tx_clk  in  1  clock; all logic on the rising edge
rstn  in  1  reset, synchronous, active-low
rx_data  in  8  received byte from the RGMII interface
rx_valid  in  1  byte valid; contiguous high for the whole frame, low in the gap
crc_data  in  32  running CRC32 from the shared CRC core, final form, byte0 = crc_data[7:0]
crc_din  out  8  byte fed to the CRC core (rx_data registered)
crc_en  out  1  CRC core enable, aligned with crc_din
crc_init  out  1  CRC core reset
arp_rx_done  out  1  one-cycle pulse: a good ARP frame was received
arp_rx_err  out  1  one-cycle pulse: a frame was rejected
arp_rx_op  out  1  1 = request (op 0001), 0 = reply (op 0002)
src_mac  out  48  ARP sender hardware address, MSB = first byte on wire
src_ip  out  32  ARP sender protocol address

Behaviour:
- Reset values: all outputs 0, except crc_init = 1. State = IDLE, counters 0, error flag cleared.
- Byte counter cnt (7 bits) indexes the frame body: 0 = first destination MAC byte, 59 = last pad byte, 60..63 = FCS.
- State machine:
  - IDLE: if rx_valid && rx_data==8'h55 go to PREAMBLE. If rx_valid with any other byte go to DROP.
  - PREAMBLE: 8'h55 stays in PREAMBLE. 8'hd5 goes to BODY with cnt=0, but only if at least 1 and at most 7 bytes of 8'h55 were seen. Any other byte, a preamble longer than 7 bytes, or rx_valid low goes to DROP.
  - BODY: each valid byte increments cnt. At cnt 59, go to FCS.
  - FCS: bytes 60..63 are captured into fcs_rx (byte 60 goes to fcs_rx[7:0]). After byte 63, go to CHECK.
  - CHECK: waits for rx_valid low, then 2 more cycles for CRC settling. It then issues either the done pulse or the err pulse and returns to IDLE. A valid byte while in CHECK (frame too long) sets the error flag, and the frame is resolved only when rx_valid goes low.
  - DROP: waits for rx_valid low. Pulses arp_rx_err only if the drop occurred after the SFD; no pulse for line noise before the SFD. Then returns to IDLE.
- rx_valid low in BODY or FCS: set the error flag and go to DROP, which pulses arp_rx_err once.
- Field checks, per byte in BODY; any mismatch sets the error flag but parsing continues to the end:
  - cnt 0-5: destination MAC, must equal FPGA_MAC or be all 8'hff.
  - cnt 12-13: EtherType, must be 08 06.
  - cnt 14-15: hardware type, must be 00 01.
  - cnt 16-17: protocol type, must be 08 00.
  - cnt 18: hardware address length, must be 06.
  - cnt 19: protocol address length, must be 04.
  - cnt 20-21: opcode, must be 00 01 or 00 02.
  - cnt 22-27: sender MAC, shifted into a shadow register.
  - cnt 28-31: sender IP, shifted into a shadow register.
  - cnt 32-37: target MAC, ignored.
  - cnt 38-41: target IP, must equal FPGA_IP.
  - cnt 42-59: padding, ignored.
- Shadow registers are copied to arp_rx_op, src_mac and src_ip only in the cycle arp_rx_done pulses. Otherwise these outputs hold the last good frame's values.
- CRC interface:
  - crc_init = 1 in IDLE/PREAMBLE, 0 otherwise.
  - crc_din is rx_data registered by 1 cycle.
  - crc_en is high exactly for the 60 body bytes (cnt 0-59), delayed 1 cycle so it aligns with crc_din.
  - crc_data is stable from 1 cycle after the last crc_en onward.
  - In CHECK, a frame with CRC_CHECK=1 and fcs_rx != crc_data is rejected.
- Latency: arp_rx_done asserts 3 cycles after the first cycle with rx_valid low following FCS byte 63.
- done and err never assert in the same cycle. Each frame produces at most one pulse.
- Reset mid-frame: the next cycle is IDLE. The remaining bytes of the interrupted frame fail the preamble check and go to DROP, with no err pulse.

Decomposition:
- Shared package arp_pkg:
  - EtherType 16'h0806, HTYPE 16'h0001, PTYPE 16'h0800, HLEN 8'h06, PLEN 8'h04.
  - OP_REQ 16'h0001, OP_REP 16'h0002.
  - Preamble 8'h55, SFD 8'hd5.
  - Body length 60, FCS length 4.
  - State enum, also used by arp_tx.
- The CRC32 core stays external and is shared with arp_tx. No sub-module inside arp_rx; the field checks are a cnt-indexed case inside the single FSM module.

Test Plan:
- Request with 7x55, d5, dst ff:ff:ff:ff:ff:ff, sender 00:0a:35:01:fe:c0 / c0.a8.00.02, target IP c0.a8.00.03, correct FCS -> one arp_rx_done pulse, arp_rx_op=1, src_mac=48'h000a3501fec0, src_ip=32'hc0a80002.
- Reply (op 00 02) with dst 00:11:22:33:44:55 -> done with arp_rx_op=0. Same frame with dst 00:11:22:33:44:56 -> arp_rx_err, outputs unchanged.
- Target IP c0.a8.00.04, or EtherType 08 00 -> arp_rx_err only, no done.
- Good frame with one FCS byte flipped -> arp_rx_err when CRC_CHECK=1. The same frame gives done when CRC_CHECK=0.
- rx_valid dropped after cnt 30 -> a single err pulse. An immediately following good frame -> done with the new values.
- rstn low during cnt 20, released while the frame continues -> no done or err for that frame. Check crc_init=1 during reset. The next good frame is accepted.
